pkt_frame_fsm_mc: RTL
=====================

Name: pkt_frame_fsm_mc

Overview:
- Multi-channel successor to the single-channel IDLE/HEAD/DATA/TAIL packet framing FSM.
- Tracks interleaved packet framing for NUM_CH channels on one beat bus; one FSM state and one length counter per channel.
- Emits registered, framing-annotated beats (sop/eop/length) and error pulses.
- Sits between the link receiver and the packet buffer; per-channel state is exported for FSM coverage.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CH_W, 2, channel-id width; 2**CH_W >= NUM_CH
DATA_W, 8, beat payload width
LEN_W, 8, packet length counter width
MAX_LEN, 16, max beats per packet (2..2**LEN_W-1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
valid  in  1  beat present this cycle
head  in  1  beat is first of packet (qualified by valid)
tail  in  1  beat is last of packet (qualified by valid)
ch  in  CH_W  channel of beat
data  in  DATA_W  beat payload
out_valid  out  1  annotated beat valid
out_ch  out  CH_W  channel of output beat
out_data  out  DATA_W  payload of output beat
out_sop  out  1  output beat starts a packet
out_eop  out  1  output beat ends a packet (normal or forced)
out_len  out  LEN_W  beat count incl. this beat; meaningful only when out_eop=1, else 0
err  out  1  one-cycle error pulse
err_code  out  3  0 none, 1 NOHEAD, 2 DUPHEAD, 3 OVERLEN, 4 BADCH
ch_state  out  2*NUM_CH  per-channel state, channel n at bits [2n+1:2n]

Behaviour:
- States per channel: IDLE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11.
- Only the channel addressed by ch with valid=1 takes a beat. All other channels: TAIL->IDLE; IDLE/HEAD/DATA hold.
- Beat transitions, for channel in IDLE or TAIL:
  - head&tail -> TAIL; sop=eop=1, len=1.
  - head only -> HEAD; sop=1, count=1.
  - no head -> IDLE; beat dropped (out_valid=0), err code 1.
- Beat transitions, for channel in HEAD or DATA (count c before this beat):
  - head set -> previous packet abandoned, no eop for it. Beat becomes new sop with err code 2, count=1. Next state is HEAD, or TAIL if tail also set (then eop=1, len=1).
  - tail, no head -> TAIL; eop=1, len=c+1.
  - neither, c+1<MAX_LEN -> DATA; count=c+1.
  - neither, c+1==MAX_LEN -> forced eop=1, len=MAX_LEN, err code 3, state IDLE. Later non-head beats on the channel raise NOHEAD.
- Same-channel beat while the channel is in HEAD/DATA/TAIL follows the rules above with no bubble; back-to-back packets are legal.
- ch>=NUM_CH with valid=1: beat dropped, err code 4, no state change.
- Latency and gating:
  - All outputs registered, 1-cycle latency from the input beat.
  - out_ch/out_data are copies of the input beat.
  - out_sop/out_eop/out_len are 0 whenever out_valid=0.
  - err is high iff err_code!=0.
- Counter never exceeds MAX_LEN; no wrap.
- Reset (including mid-packet):
  - All channel states go to IDLE and all counters to 0.
  - All outputs go to 0 on the cycle after reset is sampled high.
  - A beat presented while reset=1 is ignored.
- No backpressure; a beat is accepted every cycle valid=1.

Test Plan:
- Reset, then ch=1 beats head / plain / plain / tail -> four out_valid pulses: sop on 1st, eop on 4th, out_len=4, err=0; ch_state[3:2] sequence 01,10,10,11, then 00.
- Interleave ch0 (head, tail) with ch2 (head, plain, tail), alternating cycles -> ch0 eop len=2, ch2 eop len=3, no errors, other channels stay 00.
- ch3 plain beat while IDLE -> out_valid=0, err=1, err_code=1. ch3 head during DATA -> sop=1, err_code=2; a following tail gives len=2.
- ch0 head plus 15 plain beats (MAX_LEN=16) -> 16th beat out_eop=1, out_len=16, err_code=3, ch0 IDLE. Repeat with tail on beat 16 -> normal eop, len=16, err=0.
- Single-beat packet head&tail on ch1 -> sop=eop=1, len=1. With NUM_CH=3, CH_W=2, ch=3 beat -> err_code=4, no out_valid.
- Reset asserted for one cycle mid-packet on ch2 (state DATA) -> all ch_state 0, outputs 0. Next plain beat on ch2 -> NOHEAD.

Source files
------------

// File: rtl/pkt_frame_fsm_mc_if.sv
// Beat bus between the link receiver and the multi-channel framer.
// Handshake: a beat is transferred on every rising clk edge where valid=1;
// there is no ready/backpressure, so the receiver must accept every beat.
// Annotated beats come back one cycle later, qualified by out_valid.
interface pkt_frame_fsm_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic                valid;
    logic                head;
    logic                tail;
    logic [CH_W-1:0]     ch;
    logic [DATA_W-1:0]   data;

    logic                out_valid;
    logic [CH_W-1:0]     out_ch;
    logic [DATA_W-1:0]   out_data;
    logic                out_sop;
    logic                out_eop;
    logic [LEN_W-1:0]    out_len;
    logic                err;
    logic [2:0]          err_code;
    logic [2*NUM_CH-1:0] ch_state;

    // Beat source side (link receiver / testbench).
    modport master (
        output valid, head, tail, ch, data,
        input  out_valid, out_ch, out_data, out_sop, out_eop, out_len,
        input  err, err_code, ch_state
    );

    // Framer side.
    modport slave (
        input  valid, head, tail, ch, data,
        output out_valid, out_ch, out_data, out_sop, out_eop, out_len,
        output err, err_code, ch_state
    );
endinterface

// File: rtl/pkt_frame_fsm_mc.sv
// Multi-channel packet framing tracker: one IDLE/HEAD/DATA/TAIL state and one
// beat counter per channel, annotating interleaved beats with sop/eop/length
// and flagging framing errors. All outputs are registered (1-cycle latency).
module pkt_frame_fsm_mc #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pkt_frame_fsm_mc_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        DATA = 2'b10,
        TAIL = 2'b11
    } state_e;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_NOHEAD  = 3'd1;
    localparam logic [2:0] E_DUPHEAD = 3'd2;
    localparam logic [2:0] E_OVERLEN = 3'd3;
    localparam logic [2:0] E_BADCH   = 3'd4;

    state_e           state_q [NUM_CH];
    state_e           state_d [NUM_CH];
    logic [LEN_W-1:0] cnt_q   [NUM_CH];
    logic [LEN_W-1:0] cnt_d   [NUM_CH];

    logic              ch_ok;
    logic [NUM_CH-1:0] hit;
    state_e            sel_state;
    logic [LEN_W-1:0]  sel_cnt;
    logic [LEN_W-1:0]  cnt_inc;
    logic              at_max;
    logic              in_pkt;

    logic              out_valid_d, out_sop_d, out_eop_d;
    logic [LEN_W-1:0]  out_len_d;
    logic [2:0]        err_code_d;

    logic              out_valid_q, out_sop_q, out_eop_q, err_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [DATA_W-1:0] out_data_q;
    logic [LEN_W-1:0]  out_len_q;
    logic [2:0]        err_code_q;

    // Decode the addressed channel and pick up its current state and count.
    always_comb begin
        ch_ok     = 1'b0;
        hit       = '0;
        sel_state = IDLE;
        sel_cnt   = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (bus.ch == CH_W'(n)) begin
                ch_ok     = 1'b1;
                hit[n]    = bus.valid;
                sel_state = state_q[n];
                sel_cnt   = cnt_q[n];
            end
        end
    end

    assign cnt_inc = sel_cnt + LEN_W'(1);
    assign at_max  = (cnt_inc == LEN_W'(MAX_LEN));
    assign in_pkt  = (sel_state == HEAD) || (sel_state == DATA);

    // Per-channel state and counter registers.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_CH; n++) begin
            if (reset) begin
                state_q[n] <= IDLE;
                cnt_q[n]   <= '0;
            end else begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    // Next state: the addressed channel follows the beat rules, idle channels
    // only leave TAIL (a finished packet lasts one cycle in TAIL).
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            if (hit[n]) begin
                if (!in_pkt) begin
                    if (bus.head) begin
                        state_d[n] = bus.tail ? TAIL : HEAD;
                        cnt_d[n]   = LEN_W'(1);
                    end else begin
                        state_d[n] = IDLE;
                        cnt_d[n]   = '0;
                    end
                end else if (bus.head) begin
                    // Restart: the open packet is abandoned without an eop.
                    state_d[n] = bus.tail ? TAIL : HEAD;
                    cnt_d[n]   = LEN_W'(1);
                end else if (bus.tail) begin
                    state_d[n] = TAIL;
                    cnt_d[n]   = cnt_inc;
                end else if (!at_max) begin
                    state_d[n] = DATA;
                    cnt_d[n]   = cnt_inc;
                end else begin
                    state_d[n] = IDLE;
                    cnt_d[n]   = '0;
                end
            end else if (state_q[n] == TAIL) begin
                state_d[n] = IDLE;
                cnt_d[n]   = '0;
            end
        end
    end

    // Annotation and error code for the current beat, registered below.
    always_comb begin
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        out_len_d   = '0;
        err_code_d  = E_NONE;
        if (bus.valid) begin
            if (!ch_ok) begin
                err_code_d = E_BADCH;
            end else if (!in_pkt) begin
                if (bus.head) begin
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b1;
                    if (bus.tail) begin
                        out_eop_d = 1'b1;
                        out_len_d = LEN_W'(1);
                    end
                end else begin
                    err_code_d = E_NOHEAD;
                end
            end else begin
                out_valid_d = 1'b1;
                if (bus.head) begin
                    out_sop_d  = 1'b1;
                    err_code_d = E_DUPHEAD;
                    if (bus.tail) begin
                        out_eop_d = 1'b1;
                        out_len_d = LEN_W'(1);
                    end
                end else if (bus.tail) begin
                    out_eop_d = 1'b1;
                    out_len_d = cnt_inc;
                end else if (at_max) begin
                    out_eop_d  = 1'b1;
                    out_len_d  = LEN_W'(MAX_LEN);
                    err_code_d = E_OVERLEN;
                end
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_len_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= E_NONE;
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= bus.ch;
            out_data_q  <= bus.data;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_len_q   <= out_len_d;
            err_q       <= (err_code_d != E_NONE);
            err_code_q  <= err_code_d;
        end
    end

    // Export per-channel state for coverage, channel n at bits [2n+1:2n].
    always_comb begin
        bus.ch_state = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            bus.ch_state[2*n +: 2] = state_q[n];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_len   = out_len_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule
